gamepad_pmod_multi: RTL and testbench

Parametrised serial receiver and decoder for the Gamepad Pmod that supports 1 to 4 controllers in one block. It adds four things the single- and dual-pad interfaces lack:
- frame-length checking;
- per-button press/release event pulses;
- a link watchdog that drops stale button state;
- variable controller count within one frame.

It sits between the `ui_in` Pmod pins and game/display logic, replacing `gamepad_pmod_single`/`gamepad_pmod_dual` in new designs.

---
 rtl/gamepad_pmod_multi.sv | 158 +++++++++++++++
 tb/tb_gamepad_pmod_multi.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gamepad_pmod_multi.sv
// Gamepad Pmod receiver for 1..4 pads with frame-length checking,
// press/release event pulses and a link watchdog.
module gamepad_pmod_multi #(
  parameter int NUM_PADS       = 2,
  parameter int BITS_PER_PAD   = 12,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               pmod_data,
  input  logic                               pmod_clk,
  input  logic                               pmod_latch,
  output logic [NUM_PADS*BITS_PER_PAD-1:0]   buttons,
  output logic [NUM_PADS*BITS_PER_PAD-1:0]   pressed_evt,
  output logic [NUM_PADS*BITS_PER_PAD-1:0]   released_evt,
  output logic [NUM_PADS-1:0]                is_present,
  output logic                               frame_valid,
  output logic                               frame_error,
  output logic                               link_timeout
);

  localparam int TOTAL = NUM_PADS * BITS_PER_PAD;
  localparam int CW    = $clog2(TOTAL + 2);
  localparam int WW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_SAT = CW'(TOTAL + 1);
  localparam logic [WW-1:0] WD_MAX  = WW'(TIMEOUT_CYCLES);
  localparam logic [BITS_PER_PAD-1:0] ONES = '1;

  logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] latch_sync_q, latch_sync_d;
  logic                   clk_edge_q, latch_edge_q;
  logic [TOTAL-1:0]       shift_q, shift_d;
  logic [TOTAL-1:0]       raw_q, raw_d;
  logic [CW-1:0]          bitcnt_q, bitcnt_d;
  logic [WW-1:0]          wd_q, wd_d;
  logic                   frame_valid_q, frame_valid_d;
  logic                   frame_error_q, frame_error_d;
  logic [TOTAL-1:0]       buttons_q, buttons_d;
  logic [TOTAL-1:0]       prev_q, prev_d;
  logic [TOTAL-1:0]       pressed_q, pressed_d;
  logic [TOTAL-1:0]       released_q, released_d;
  logic [NUM_PADS-1:0]    present_q, present_d;

  logic data_s, clk_rise, latch_rise, len_ok, accept;
  logic [BITS_PER_PAD-1:0] slot;

  assign data_s     = data_sync_q[SYNC_STAGES-1];
  assign clk_rise   = clk_sync_q[SYNC_STAGES-1] & ~clk_edge_q;
  assign latch_rise = latch_sync_q[SYNC_STAGES-1] & ~latch_edge_q;

  assign link_timeout = (wd_q == WD_MAX);
  assign buttons      = buttons_q;
  assign pressed_evt  = pressed_q;
  assign released_evt = released_q;
  assign is_present   = present_q;
  assign frame_valid  = frame_valid_q;
  assign frame_error  = frame_error_q;

  always_comb begin
    data_sync_d  = {data_sync_q[SYNC_STAGES-2:0], pmod_data};
    clk_sync_d   = {clk_sync_q[SYNC_STAGES-2:0], pmod_clk};
    latch_sync_d = {latch_sync_q[SYNC_STAGES-2:0], pmod_latch};
  end

  // A latch coinciding with a clock edge checks the post-edge count.
  always_comb begin
    shift_d       = shift_q;
    bitcnt_d      = bitcnt_q;
    raw_d         = raw_q;
    frame_valid_d = 1'b0;
    frame_error_d = 1'b0;
    len_ok        = 1'b0;
    accept        = 1'b0;
    if (clk_rise) begin
      shift_d = {shift_q[TOTAL-2:0], data_s};
      if (bitcnt_q != CNT_SAT)
        bitcnt_d = bitcnt_q + 1'b1;
    end
    for (int k = 1; k <= NUM_PADS; k++)
      if (bitcnt_d == CW'(k * BITS_PER_PAD))
        len_ok = 1'b1;
    if (latch_rise) begin
      accept = len_ok;
      if (len_ok) begin
        raw_d         = shift_d;
        frame_valid_d = 1'b1;
      end else begin
        frame_error_d = 1'b1;
      end
      shift_d  = '1;
      bitcnt_d = '0;
    end
  end

  always_comb begin
    wd_d = wd_q;
    if (accept)
      wd_d = '0;
    else if (wd_q != WD_MAX)
      wd_d = wd_q + 1'b1;
  end

  always_comb begin
    buttons_d = '0;
    present_d = '0;
    slot      = '0;
    for (int k = 0; k < NUM_PADS; k++) begin
      slot         = raw_q[k*BITS_PER_PAD +: BITS_PER_PAD];
      present_d[k] = (slot != ONES) && !link_timeout;
      if (present_d[k])
        buttons_d[k*BITS_PER_PAD +: BITS_PER_PAD] = slot;
    end
    prev_d     = buttons_q;
    pressed_d  = buttons_q & ~prev_q;
    released_d = ~buttons_q & prev_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_sync_q   <= '0;
      clk_sync_q    <= '0;
      latch_sync_q  <= '0;
      clk_edge_q    <= 1'b0;
      latch_edge_q  <= 1'b0;
      shift_q       <= '1;
      raw_q         <= '1;
      bitcnt_q      <= '0;
      wd_q          <= '0;
      frame_valid_q <= 1'b0;
      frame_error_q <= 1'b0;
      buttons_q     <= '0;
      prev_q        <= '0;
      pressed_q     <= '0;
      released_q    <= '0;
      present_q     <= '0;
    end else begin
      data_sync_q   <= data_sync_d;
      clk_sync_q    <= clk_sync_d;
      latch_sync_q  <= latch_sync_d;
      clk_edge_q    <= clk_sync_q[SYNC_STAGES-1];
      latch_edge_q  <= latch_sync_q[SYNC_STAGES-1];
      shift_q       <= shift_d;
      raw_q         <= raw_d;
      bitcnt_q      <= bitcnt_d;
      wd_q          <= wd_d;
      frame_valid_q <= frame_valid_d;
      frame_error_q <= frame_error_d;
      buttons_q     <= buttons_d;
      prev_q        <= prev_d;
      pressed_q     <= pressed_d;
      released_q    <= released_d;
      present_q     <= present_d;
    end
  end

endmodule

// File: tb/tb_gamepad_pmod_multi.sv
// Directed bench for gamepad_pmod_multi: framing, events,
// watchdog, mid-frame reset and coincident clock/latch edges.
module tb_gamepad_pmod_multi;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pmod_data = 1'b0;
  logic pmod_clk = 1'b0;
  logic pmod_latch = 1'b0;

  logic [23:0] buttons, pressed_evt, released_evt;
  logic [1:0]  is_present;
  logic        frame_valid, frame_error, link_timeout;

  logic [23:0] w_buttons, w_pressed_evt, w_released_evt;
  logic [1:0]  w_is_present;
  logic        w_frame_valid, w_frame_error, w_link_timeout;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  gamepad_pmod_multi #(
    .NUM_PADS(2), .BITS_PER_PAD(12),
    .SYNC_STAGES(2), .TIMEOUT_CYCLES(4096)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .pmod_data(pmod_data), .pmod_clk(pmod_clk),
    .pmod_latch(pmod_latch),
    .buttons(buttons), .pressed_evt(pressed_evt),
    .released_evt(released_evt), .is_present(is_present),
    .frame_valid(frame_valid), .frame_error(frame_error),
    .link_timeout(link_timeout)
  );

  gamepad_pmod_multi #(
    .NUM_PADS(2), .BITS_PER_PAD(12),
    .SYNC_STAGES(2), .TIMEOUT_CYCLES(64)
  ) dut_wd (
    .clk(clk), .rst_n(rst_n),
    .pmod_data(pmod_data), .pmod_clk(pmod_clk),
    .pmod_latch(pmod_latch),
    .buttons(w_buttons), .pressed_evt(w_pressed_evt),
    .released_evt(w_released_evt), .is_present(w_is_present),
    .frame_valid(w_frame_valid), .frame_error(w_frame_error),
    .link_timeout(w_link_timeout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [23:0] val, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      pmod_data = val[i];
      pmod_clk  = 1'b0;
      repeat (4) tick();
      pmod_clk = 1'b1;
      repeat (4) tick();
    end
    pmod_clk = 1'b0;
  endtask

  task automatic do_latch(output logic fv, output logic fe);
    fv = 1'b0;
    fe = 1'b0;
    pmod_latch = 1'b1;
    for (int i = 0; i < 16 && !fv && !fe; i++) begin
      tick();
      fv = frame_valid;
      fe = frame_error;
    end
    pmod_latch = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if (buttons !== 24'h0 || is_present !== 2'b00) begin
      errors++;
      $display("FAIL rst_hold: buttons=%h pres=%b want 0", buttons, is_present);
    end
    checks++;
    if (frame_valid !== 1'b0 || frame_error !== 1'b0 || link_timeout !== 1'b0) begin
      errors++;
      $display("FAIL rst_flags: fv=%b fe=%b lt=%b want 0", frame_valid, frame_error, link_timeout);
    end
    rst_n = 1'b1;
    repeat (3) tick();
    checks++;
    if (buttons !== 24'h0 || is_present !== 2'b00 || pressed_evt !== 24'h0) begin
      errors++;
      $display("FAIL rst_after: buttons=%h pres=%b prs=%h want 0", buttons, is_present, pressed_evt);
    end
  endtask

  task automatic test_single();
    logic fv, fe;
    send_bits(24'h000801, 12);
    do_latch(fv, fe);
    checks++;
    if (fv !== 1'b1 || fe !== 1'b0) begin
      errors++;
      $display("FAIL single_accept: fv=%b fe=%b want 1 0", fv, fe);
    end
    tick();
    checks++;
    if (frame_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_pulse: fv=%b want 0", frame_valid);
    end
    checks++;
    if (buttons !== 24'h000801 || is_present !== 2'b01) begin
      errors++;
      $display("FAIL single_dec: buttons=%h pres=%b want 000801 01", buttons, is_present);
    end
    tick();
    checks++;
    if (pressed_evt !== 24'h000801 || released_evt !== 24'h0) begin
      errors++;
      $display("FAIL single_evt: prs=%h rel=%h want 000801 0", pressed_evt, released_evt);
    end
    tick();
    checks++;
    if (pressed_evt !== 24'h0) begin
      errors++;
      $display("FAIL single_evt_end: prs=%h want 0", pressed_evt);
    end
  endtask

  task automatic test_full();
    logic fv, fe;
    send_bits(24'h010000, 24);
    do_latch(fv, fe);
    tick();
    checks++;
    if (fv !== 1'b1 || buttons !== 24'h010000 || is_present !== 2'b11) begin
      errors++;
      $display("FAIL full_dec: fv=%b buttons=%h pres=%b want 1 010000 11", fv, buttons, is_present);
    end
    tick();
    checks++;
    if (pressed_evt !== 24'h010000 || released_evt !== 24'h000801) begin
      errors++;
      $display("FAIL full_evt: prs=%h rel=%h want 010000 000801", pressed_evt, released_evt);
    end
    send_bits(24'h000000, 24);
    do_latch(fv, fe);
    tick();
    checks++;
    if (fv !== 1'b1 || buttons !== 24'h0 || is_present !== 2'b11) begin
      errors++;
      $display("FAIL zero_dec: fv=%b buttons=%h pres=%b want 1 0 11", fv, buttons, is_present);
    end
    tick();
    checks++;
    if (released_evt !== 24'h010000 || pressed_evt !== 24'h0) begin
      errors++;
      $display("FAIL zero_rel: rel=%h prs=%h want 010000 0", released_evt, pressed_evt);
    end
    tick();
    checks++;
    if (released_evt !== 24'h0) begin
      errors++;
      $display("FAIL zero_rel_end: rel=%h want 0", released_evt);
    end
  endtask

  task automatic test_bad_frame();
    logic fv, fe;
    send_bits(24'h123456, 24);
    do_latch(fv, fe);
    repeat (3) tick();
    checks++;
    if (buttons !== 24'h123456) begin
      errors++;
      $display("FAIL bad_pre: buttons=%h want 123456", buttons);
    end
    send_bits(24'h000000, 13);
    do_latch(fv, fe);
    checks++;
    if (fe !== 1'b1 || fv !== 1'b0) begin
      errors++;
      $display("FAIL bad_reject: fv=%b fe=%b want 0 1", fv, fe);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (buttons !== 24'h123456 || pressed_evt !== 24'h0 || released_evt !== 24'h0) begin
        errors++;
        $display("FAIL bad_hold%0d: buttons=%h prs=%h rel=%h want 123456 0 0", i, buttons, pressed_evt, released_evt);
      end
    end
    send_bits(24'h00000F, 12);
    do_latch(fv, fe);
    tick();
    checks++;
    if (fv !== 1'b1 || buttons !== 24'h00000F || is_present !== 2'b01) begin
      errors++;
      $display("FAIL bad_next: fv=%b buttons=%h pres=%b want 1 00000f 01", fv, buttons, is_present);
    end
  endtask

  task automatic test_simultaneous();
    logic fv, fe;
    logic [23:0] val;
    val = 24'h000ABC;
    send_bits(val >> 1, 11);
    pmod_data = val[0];
    pmod_clk  = 1'b0;
    repeat (4) tick();
    pmod_clk = 1'b1;
    do_latch(fv, fe);
    checks++;
    if (fv !== 1'b1 || fe !== 1'b0) begin
      errors++;
      $display("FAIL simul_accept: fv=%b fe=%b want 1 0", fv, fe);
    end
    tick();
    checks++;
    if (buttons !== 24'h000ABC || is_present !== 2'b01) begin
      errors++;
      $display("FAIL simul_dec: buttons=%h pres=%b want 000abc 01", buttons, is_present);
    end
    pmod_clk = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_watchdog();
    logic fv, fe;
    int n;
    send_bits(24'h000801, 12);
    do_latch(fv, fe);
    checks++;
    if (w_frame_valid !== 1'b1 || w_link_timeout !== 1'b0) begin
      errors++;
      $display("FAIL wd_accept: fv=%b lt=%b want 1 0", w_frame_valid, w_link_timeout);
    end
    tick();
    n = 1;
    checks++;
    if (w_buttons !== 24'h000801) begin
      errors++;
      $display("FAIL wd_held: buttons=%h want 000801", w_buttons);
    end
    while (!w_link_timeout && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 64) begin
      errors++;
      $display("FAIL wd_delay: cycles=%0d want 64", n);
    end
    tick();
    checks++;
    if (w_buttons !== 24'h0 || w_is_present !== 2'b00) begin
      errors++;
      $display("FAIL wd_clear: buttons=%h pres=%b want 0 00", w_buttons, w_is_present);
    end
    tick();
    checks++;
    if (w_released_evt !== 24'h000801) begin
      errors++;
      $display("FAIL wd_rel: rel=%h want 000801", w_released_evt);
    end
    send_bits(24'h000801, 12);
    do_latch(fv, fe);
    checks++;
    if (w_frame_valid !== 1'b1 || w_link_timeout !== 1'b0) begin
      errors++;
      $display("FAIL wd_recover: fv=%b lt=%b want 1 0", w_frame_valid, w_link_timeout);
    end
    repeat (3) tick();
  endtask

  task automatic test_reset_mid();
    logic fv, fe;
    checks++;
    if (buttons !== 24'h000801) begin
      errors++;
      $display("FAIL mid_pre: buttons=%h want 000801", buttons);
    end
    send_bits(24'h000016, 5);
    rst_n = 1'b0;
    #1;
    checks++;
    if (buttons !== 24'h0 || is_present !== 2'b00 || pressed_evt !== 24'h0 || released_evt !== 24'h0) begin
      errors++;
      $display("FAIL mid_rst: buttons=%h pres=%b prs=%h rel=%h want 0", buttons, is_present, pressed_evt, released_evt);
    end
    checks++;
    if (frame_valid !== 1'b0 || frame_error !== 1'b0 || link_timeout !== 1'b0) begin
      errors++;
      $display("FAIL mid_flags: fv=%b fe=%b lt=%b want 0", frame_valid, frame_error, link_timeout);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    send_bits(24'hA5A3C3, 24);
    do_latch(fv, fe);
    checks++;
    if (fv !== 1'b1 || fe !== 1'b0) begin
      errors++;
      $display("FAIL mid_accept: fv=%b fe=%b want 1 0", fv, fe);
    end
    tick();
    checks++;
    if (buttons !== 24'hA5A3C3 || is_present !== 2'b11) begin
      errors++;
      $display("FAIL mid_dec: buttons=%h pres=%b want a5a3c3 11", buttons, is_present);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_full();
    test_bad_frame();
    test_simultaneous();
    test_watchdog();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
